// File: rtl/sdram_bist_pkg.sv
// Shared types and constants for the SDRAM BIST engine:
// FSM state encoding, pattern codes, LFSR taps and checkerboard words.
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RW,
        ST_FIN,
        ST_DONE
    } bist_state_e;

    typedef enum logic [1:0] {
        PAT_ADDR  = 2'd0,
        PAT_LFSR  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_RSVD  = 2'd3
    } pat_mode_e;

    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] CHECK_EVEN = 32'hAAAA_AAAA;
    localparam logic [31:0] CHECK_ODD  = 32'h5555_5555;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/bist_pattern_gen.sv
// Test pattern source shared by the write and read passes.
// Ports: clk/rst, mode, addr, load (reseed LFSR), advance (step LFSR), pattern.
module bist_pattern_gen
    import sdram_bist_pkg::*;
#(
    parameter int          ADDR_W    = 23,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst,
    input  pat_mode_e         mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] pattern
);

    logic [31:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr <= LFSR_SEED;
        end else if (advance) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    always_comb begin
        pattern = DATA_W'(addr);
        unique case (mode)
            PAT_LFSR:  pattern = DATA_W'(lfsr);
            PAT_CHECK: pattern = addr[0] ? DATA_W'(CHECK_ODD)
                                         : DATA_W'(CHECK_EVEN);
            default:   pattern = DATA_W'(addr);
        endcase
    end

endmodule

// File: rtl/sdram_bist_engine.sv
// Write-then-verify BIST master on the SDRAM controller command port.
// Ports: clk/rst, start/pattern_sel, cmd_* command port, data_out read
// return, busy/done/pass/timeout status, err_count, first_err_*, cur_addr.
module sdram_bist_engine
    import sdram_bist_pkg::*;
#(
    parameter int                ADDR_W      = 23,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_LAST   = 23'h7F_FFFF,
    parameter logic [31:0]       LFSR_SEED   = 32'h0000_0001,
    parameter int                RD_TIMEOUT  = 1024,
    parameter bit                STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic              cmd_ready,
    output logic              cmd_enable,
    output logic              cmd_wr,
    output logic [3:0]        cmd_byte_enable,
    output logic [ADDR_W-1:0] cmd_address,
    output logic [DATA_W-1:0] cmd_data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_out_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_got,
    output logic [ADDR_W-1:0] cur_addr
);

    localparam int TW = $clog2(RD_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(RD_TIMEOUT - 1);

    bist_state_e       state;
    pat_mode_e         mode_q;
    logic [TW-1:0]     tmo_cnt;
    logic [DATA_W-1:0] pat;

    logic accept;
    logic start_ok;
    logic at_last;
    logic rd_hit;
    logic mismatch;
    logic rd_stop;
    logic pg_load;
    logic pg_adv;

    assign accept   = cmd_enable && cmd_ready;
    assign start_ok = start && (state == ST_IDLE || state == ST_DONE);
    assign at_last  = (cur_addr == ADDR_LAST);
    assign rd_hit   = (state == ST_RW) && data_out_ready;
    assign mismatch = (data_out != pat);
    assign rd_stop  = at_last || (STOP_ON_ERR && mismatch);

    // The LFSR reseeds at start and again when the write pass wraps,
    // so the read pass regenerates exactly the written sequence.
    assign pg_load = start_ok
                  || (state == ST_WR && accept && at_last);
    assign pg_adv  = (state == ST_WR && accept && !at_last)
                  || (rd_hit && !rd_stop);

    assign cmd_byte_enable = 4'b1111;
    assign cmd_address     = cur_addr;
    assign cmd_data_in     = pat;

    bist_pattern_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_pat (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode_q),
        .addr    (cur_addr),
        .load    (pg_load),
        .advance (pg_adv),
        .pattern (pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            mode_q         <= PAT_ADDR;
            tmo_cnt        <= '0;
            cmd_enable     <= 1'b0;
            cmd_wr         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            cur_addr       <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q <= (pattern_sel == PAT_RSVD)
                                  ? PAT_ADDR
                                  : pat_mode_e'(pattern_sel);
                        err_count      <= '0;
                        timeout        <= 1'b0;
                        first_err_addr <= '0;
                        first_err_exp  <= '0;
                        first_err_got  <= '0;
                        cur_addr       <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        cmd_enable     <= 1'b1;
                        cmd_wr         <= 1'b1;
                        state          <= ST_WR;
                    end
                end

                // cmd_enable drops for one cycle after every accept.
                ST_WR: begin
                    if (accept) begin
                        cmd_enable <= 1'b0;
                        if (at_last) begin
                            cur_addr <= '0;
                            cmd_wr   <= 1'b0;
                            state    <= ST_RD;
                        end else begin
                            cur_addr <= cur_addr + 1'b1;
                        end
                    end else if (!cmd_enable) begin
                        cmd_enable <= 1'b1;
                    end
                end

                ST_RD: begin
                    if (accept) begin
                        cmd_enable <= 1'b0;
                        tmo_cnt    <= '0;
                        state      <= ST_RW;
                    end else if (!cmd_enable) begin
                        cmd_enable <= 1'b1;
                        cmd_wr     <= 1'b0;
                    end
                end

                // A strobe on the terminal-count cycle still wins.
                ST_RW: begin
                    if (data_out_ready) begin
                        if (mismatch) begin
                            if (err_count == '0) begin
                                first_err_addr <= cur_addr;
                                first_err_exp  <= pat;
                                first_err_got  <= data_out;
                            end
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                        if (rd_stop) begin
                            state <= ST_FIN;
                        end else begin
                            cur_addr <= cur_addr + 1'b1;
                            state    <= ST_RD;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout <= 1'b1;
                        state   <= ST_FIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !timeout;
                    state <= ST_DONE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
